irq_dispatch: RTL and testbench
===============================

// Module: irq_dispatch
// PURPOSE
//  Downstream stage of the interrupt queue controller: consumes its 3-bit code (irq1..irq3), drives its eirq pop-enable.
//  Latches one code, waits for an instruction boundary with interrupts enabled, then handshakes a vector to the CPU.
//  Captures the return PC and blocks further pops until the CPU signals reti. Holds a per-code mask; masked codes are dropped and counted.
// PARAMETERS
//  ADDR_W     16       width of PC / vector address
//  VEC_BASE   16'h0010 vector table base address
//  VEC_SHIFT  2        log2 of vector slot stride (vec = VEC_BASE + code<<VEC_SHIFT)
//  DROP_W     8        width of saturating dropped-interrupt counter
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       reset, asynchronous, active-low
//  irq1..irq3  in   1 each  code bits 0..2 from queue controller; valid only while eirq=1
//  eirq        out  1       pop-enable to queue controller; high only in IDLE
//  ie          in   1       CPU global interrupt enable
//  instr_done  in   1       CPU instruction boundary strobe
//  pc          in   ADDR_W  CPU next-instruction PC, sampled on irq_ack
//  irq_req     out  1       interrupt request to CPU
//  vec_addr    out  ADDR_W  vector address, stable while irq_req=1
//  irq_ack     in   1       CPU accepts request
//  reti        in   1       CPU return-from-interrupt strobe
//  ret_pc      out  ADDR_W  PC captured at irq_ack
//  cur_irq     out  3       code being serviced/pending, 0 when IDLE
//  in_service  out  1       high in SERV
//  mask_we     in   1       mask register write strobe
//  mask_wdata  in   8       new mask; bit k=1 blocks code k (bit0 ignored, reads 0)
//  mask        out  8       current mask
//  drop_cnt    out  DROP_W  count of masked codes dropped, saturating
// BEHAVIOUR
//  Reset: state IDLE, eirq=1, irq_req=0, vec_addr=0, ret_pc=0, cur_irq=0, in_service=0, mask=0, drop_cnt=0.
//  code = {irq3,irq2,irq1}; eirq = (state==IDLE), combinational from registered state.
//  FSM: IDLE -> PEND -> REQ -> SERV -> IDLE.
//  IDLE: code!=0 and mask[code]=0 -> latch cur_irq, go PEND next cycle.
//        code!=0 and mask[code]=1 -> drop, drop_cnt+1 (holds at all-ones), stay IDLE.
//  PEND: ie=1 and instr_done=1 in same cycle -> REQ next cycle; irq_req and vec_addr registered, valid from that cycle.
//        ie=0 -> wait indefinitely; a mask write in PEND does not cancel the latched code.
//  REQ: irq_req=1 held until irq_ack; on ack: ret_pc<=pc, irq_req<=0, go SERV. Minimum code->irq_req latency 2 cycles.
//  SERV: in_service=1; on reti -> IDLE, cur_irq<=0, eirq=1 from next cycle. No nesting.
//  Strobes outside their state (irq_ack outside REQ, reti outside SERV, instr_done outside PEND) are ignored.
//  irq_ack and reti in the same REQ cycle: ack only; reti is lost.
//  Mask write takes effect next cycle; a code arriving in the write cycle is checked against the old mask.
//  vec_addr: VEC_BASE + (cur_irq << VEC_SHIFT), truncated to ADDR_W, no wrap detection.
//  rst asserted mid-operation: immediate return to reset values; a held code is discarded.
// STRUCTURE
//  Shared package irq_pkg: state encoding (IDLE, PEND, REQ, SERV), IRQ_CODE_W=3, vector-address function.
//  Sub-module: sat_counter (DROP_W, inc, async active-low reset), instanced for drop_cnt.
//  Rest is a single FSM and register block.
// TESTING
//  Reset release, no stimulus -> eirq=1, all other outputs 0, drop_cnt=0.
//  Code 3, ie=1, instr_done=1 -> irq_req 2 cycles later, vec_addr=16'h001C.
//    Then ack with pc=16'h0123 -> ret_pc=16'h0123, in_service=1.
//    Then reti -> eirq=1 next cycle.
//  mask=8'h20, code 5 in IDLE -> no irq_req, drop_cnt=1, eirq stays 1.
//    300 masked codes -> drop_cnt=8'hFF.
//  Code 2 with ie=0 for 50 cycles -> PEND held, eirq=0.
//    ie=1 plus instr_done -> irq_req, vec_addr=16'h0018.
//  reti during REQ, or irq_ack during SERV -> ignored; state and outputs unchanged.
//  rst pulsed while in SERV -> all outputs back to reset values within the same cycle; mask=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatch stage: FSM encoding,
// code width and the vector-address helper.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      REQ  = 2'd2,
      SERV = 2'd3
   } state_t;

   localparam int IRQ_CODE_W = 3;

   // Caller truncates the result to its own address width.
   function automatic logic [31:0] vec_calc(input logic [31:0]           base,
                                            input int unsigned           shift,
                                            input logic [IRQ_CODE_W-1:0] code);
      return base + ({29'd0, code} << shift);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds once it reaches all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count register with saturation at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatch: pops one code from the queue controller, requests the CPU
// at an instruction boundary, captures the return PC and waits for reti.
module irq_dispatch
   import irq_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter logic [15:0] VEC_BASE  = 16'h0010,
   parameter int unsigned VEC_SHIFT = 2,
   parameter int          DROP_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              irq1,
   input  logic              irq2,
   input  logic              irq3,
   output logic              eirq,
   input  logic              ie,
   input  logic              instr_done,
   input  logic [ADDR_W-1:0] pc,
   output logic              irq_req,
   output logic [ADDR_W-1:0] vec_addr,
   input  logic              irq_ack,
   input  logic              reti,
   output logic [ADDR_W-1:0] ret_pc,
   output logic [2:0]        cur_irq,
   output logic              in_service,
   input  logic              mask_we,
   input  logic [7:0]        mask_wdata,
   output logic [7:0]        mask,
   output logic [DROP_W-1:0] drop_cnt
);

   logic [IRQ_CODE_W-1:0] code;
   state_t                state;
   state_t                state_nxt;
   logic                  do_latch;
   logic                  do_drop;
   logic                  do_req;
   logic                  do_ack;
   logic                  do_reti;

   assign code = {irq3, irq2, irq1};
   assign eirq = (state == IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and one-cycle action strobes; strobes outside their state fall through.
   always_comb begin
      state_nxt = state;
      do_latch  = 1'b0;
      do_drop   = 1'b0;
      do_req    = 1'b0;
      do_ack    = 1'b0;
      do_reti   = 1'b0;
      case (state)
         IDLE: begin
            if (code == 3'd0) begin
               state_nxt = IDLE;
            end else if (mask[code]) begin
               do_drop = 1'b1;
            end else begin
               do_latch  = 1'b1;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (ie && instr_done) begin
               do_req    = 1'b1;
               state_nxt = REQ;
            end else begin
               state_nxt = PEND;
            end
         end
         REQ: begin
            if (irq_ack) begin
               do_ack    = 1'b1;
               state_nxt = SERV;
            end else begin
               state_nxt = REQ;
            end
         end
         SERV: begin
            if (reti) begin
               do_reti   = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = SERV;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered CPU-facing outputs and mask; mask writes apply in any state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_irq    <= 3'd0;
         irq_req    <= 1'b0;
         vec_addr   <= '0;
         ret_pc     <= '0;
         in_service <= 1'b0;
         mask       <= 8'd0;
      end else begin
         if (do_latch) begin
            cur_irq <= code;
         end
         if (do_req) begin
            irq_req  <= 1'b1;
            vec_addr <= ADDR_W'(vec_calc(32'(VEC_BASE), VEC_SHIFT, cur_irq));
         end
         if (do_ack) begin
            irq_req    <= 1'b0;
            ret_pc     <= pc;
            in_service <= 1'b1;
         end
         if (do_reti) begin
            in_service <= 1'b0;
            cur_irq    <= 3'd0;
         end
         if (mask_we) begin
            mask <= {mask_wdata[7:1], 1'b0};
         end
      end
   end

   sat_counter #(.W(DROP_W)) u_drop (
      .clk (clk),
      .rst (rst),
      .inc (do_drop),
      .cnt (drop_cnt)
   );

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed and randomized bench for irq_dispatch against a rule-level reference model.
module tb_irq_dispatch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        irq1 = 1'b0, irq2 = 1'b0, irq3 = 1'b0;
   logic        eirq;
   logic        ie = 1'b0, instr_done = 1'b0;
   logic [15:0] pc = 16'd0;
   logic        irq_req;
   logic [15:0] vec_addr;
   logic        irq_ack = 1'b0, reti = 1'b0;
   logic [15:0] ret_pc;
   logic [2:0]  cur_irq;
   logic        in_service;
   logic        mask_we = 1'b0;
   logic [7:0]  mask_wdata = 8'd0;
   logic [7:0]  mask;
   logic [7:0]  drop_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model: held code (0 = nothing held) plus what the CPU side is doing with it.
   int          m_code, m_drop;
   bit          m_wait_boundary, m_requesting, m_serving;
   logic [15:0] m_vec, m_ret;
   logic [7:0]  m_mask;

   irq_dispatch dut (
      .clk(clk), .rst(rst), .irq1(irq1), .irq2(irq2), .irq3(irq3), .eirq(eirq),
      .ie(ie), .instr_done(instr_done), .pc(pc), .irq_req(irq_req), .vec_addr(vec_addr),
      .irq_ack(irq_ack), .reti(reti), .ret_pc(ret_pc), .cur_irq(cur_irq),
      .in_service(in_service), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .mask(mask), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_code = 0; m_drop = 0; m_wait_boundary = 0; m_requesting = 0; m_serving = 0;
      m_vec = 16'd0; m_ret = 16'd0; m_mask = 8'd0;
   endtask

   task automatic model_step();
      int c;
      c = {irq3, irq2, irq1};
      if (m_code == 0) begin
         if (c != 0) begin
            if (m_mask[c]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else begin m_code = c; m_wait_boundary = 1; end
         end
      end else if (m_wait_boundary) begin
         if (ie && instr_done) begin
            m_wait_boundary = 0; m_requesting = 1;
            m_vec = 16'((16'h0010 + m_code * 4) & 16'hFFFF);
         end
      end else if (m_requesting) begin
         if (irq_ack) begin m_requesting = 0; m_serving = 1; m_ret = pc; end
      end else if (m_serving) begin
         if (reti) begin m_serving = 0; m_code = 0; end
      end
      if (mask_we) m_mask = mask_wdata & 8'hFE;
   endtask

   task automatic check_all();
      chk("eirq",       32'(eirq),       32'(m_code == 0));
      chk("irq_req",    32'(irq_req),    32'(m_requesting));
      chk("vec_addr",   32'(vec_addr),   32'(m_vec));
      chk("ret_pc",     32'(ret_pc),     32'(m_ret));
      chk("cur_irq",    32'(cur_irq),    32'(m_code));
      chk("in_service", 32'(in_service), 32'(m_serving));
      chk("mask",       32'(mask),       32'(m_mask));
      chk("drop_cnt",   32'(drop_cnt),   32'(m_drop));
   endtask

   task automatic set_code(input int c);
      {irq3, irq2, irq1} = 3'(c);
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_all();
      chk("reset_eirq", 32'(eirq), 32'd1);
      chk("reset_drop", 32'(drop_cnt), 32'd0);

      // Code 3 with an immediate boundary: request two edges after the code.
      set_code(3); ie = 1'b1; instr_done = 1'b1;
      cyc();
      set_code(0);
      chk("pend_no_req", 32'(irq_req), 32'd0);
      cyc();
      chk("req_up", 32'(irq_req), 32'd1);
      chk("vec_code3", 32'(vec_addr), 32'h001C);
      instr_done = 1'b0; reti = 1'b1;
      cyc();
      chk("reti_in_req", 32'(irq_req), 32'd1);
      reti = 1'b0; irq_ack = 1'b1; pc = 16'h0123;
      cyc();
      chk("ret_pc", 32'(ret_pc), 32'h0123);
      chk("in_serv", 32'(in_service), 32'd1);
      pc = 16'h0456;
      cyc();
      chk("ack_in_serv", 32'(ret_pc), 32'h0123);
      irq_ack = 1'b0; reti = 1'b1;
      cyc();
      chk("reti_eirq", 32'(eirq), 32'd1);
      reti = 1'b0;

      // Masked code 5 is dropped and counted, saturating at all-ones.
      mask_we = 1'b1; mask_wdata = 8'h20;
      cyc();
      mask_we = 1'b0; set_code(5);
      cyc();
      chk("drop_one", 32'(drop_cnt), 32'd1);
      chk("drop_noreq", 32'(irq_req), 32'd0);
      chk("drop_eirq", 32'(eirq), 32'd1);
      repeat (299) cyc();
      chk("drop_sat", 32'(drop_cnt), 32'hFF);
      set_code(0);

      // Code 2 held pending while ie=0; a mask write does not cancel it.
      ie = 1'b0; set_code(2);
      cyc();
      set_code(0);
      for (int i = 0; i < 50; i++) begin
         instr_done = 1'(i % 2);
         mask_we = (i == 10);
         mask_wdata = 8'h24;
         cyc();
      end
      chk("pend_eirq", 32'(eirq), 32'd0);
      chk("pend_cur", 32'(cur_irq), 32'd2);
      mask_we = 1'b0; ie = 1'b1; instr_done = 1'b1;
      cyc();
      chk("req_code2", 32'(irq_req), 32'd1);
      chk("vec_code2", 32'(vec_addr), 32'h0018);
      instr_done = 1'b0; irq_ack = 1'b1; pc = 16'hBEEF;
      cyc();
      irq_ack = 1'b0;
      chk("serv2", 32'(in_service), 32'd1);

      // Asynchronous reset in SERV: outputs return without waiting for an edge.
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_mask", 32'(mask), 32'd0);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check_all();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         set_code(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
         ie         = ($urandom_range(0, 9) < 7);
         instr_done = $urandom_range(0, 1) == 1;
         irq_ack    = ($urandom_range(0, 9) < 3);
         reti       = ($urandom_range(0, 9) < 2);
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = 8'($urandom);
         pc         = 16'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b0; #1;
            model_reset();
            check_all();
            rst = 1'b1;
         end
         cyc();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
